csr_trap_unit: RTL
==================

Name: csr_trap_unit

Overview:
- Machine-mode CSR file and trap controller for the 3-stage core; sits in the execute stage beside the ALU.
- Successor to the single-interrupt CSR file. Adds the following:
  - NUM_IRQ prioritised interrupt lines.
  - Latched mepc/mcause.
  - MIE/MPIE stacking on trap and mret.
  - Direct/vectored mtvec.
  - RW/RS/RC CSR ops with legality checking.
  - 64-bit mcycle/minstret counters.

Parameters:
- XLEN, 32, datapath width; only 32 supported, so mcycleh/minstreth are always present.
- NUM_IRQ, 4, platform interrupt lines, 1..16. Line k maps to mip/mie bit 16+k.
- MTVEC_RESET, 32'h0000_0000, mtvec reset value.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- instr_valid  in  1  valid instruction in execute this cycle.
- pc_i  in  XLEN  PC of that instruction.
- csr_op  in  2  00 none, 01 RW, 10 RS (set), 11 RC (clear).
- csr_addr  in  12  CSR address.
- csr_wdata  in  XLEN  write operand (rs1 value or zimm).
- is_mret  in  1  instruction is MRET.
- retire  in  1  instruction completes this cycle.
- irq_i  in  NUM_IRQ  level interrupt requests, already synchronous to clk.
- csr_rdata  out  XLEN  old CSR value, combinational.
- illegal_csr  out  1  access illegal, combinational.
- trap_taken  out  1  redirect fetch this cycle, combinational.
- trap_pc  out  XLEN  redirect target.

Behaviour:
- Reset: all CSRs 0 except mtvec=MTVEC_RESET, mip=0, counters=0. Outputs low/zero with instr_valid=0.
- Implemented CSRs:
  - mstatus 0x300: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; reset reads 0x1800.
  - mie 0x304: bits 16..16+NUM_IRQ-1 writable, others read 0.
  - mtvec 0x305: bit1 forced 0; mode = bit0 (0 direct, 1 vectored).
  - mscratch 0x340.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342: fully writable.
  - mip 0x344: read-only.
  - mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82.
- mip update: mip[16+k] <= irq_i[k] every cycle, so there is 1 cycle of latency from irq_i to pending.
- CSR access (csr_op!=0 and instr_valid):
  - csr_rdata = current value.
  - New value: RW = wdata; RS = old | wdata; RC = old & ~wdata. Masks above are then applied.
  - The write commits at the clock edge.
- illegal_csr = 1 when csr_op!=0 and instr_valid and either:
  - the address is not implemented, or
  - the access writes a read-only CSR: mip, or addr[11:10]==2'b11.
  - Illegal accesses are not written, and csr_rdata=0.
- csr_rdata=0 when csr_op==00.
- Interrupt take:
  - pending = mip & mie.
  - take = instr_valid & mstatus.MIE & |pending.
  - The lowest active k wins.
  - Same cycle: trap_taken=1.
    - Direct mode: trap_pc = {mtvec[31:2],2'b00}.
    - Vectored mode: trap_pc = {mtvec[31:2],2'b00} + 4*(16+k).
  - At the edge:
    - mepc <= pc_i; mcause <= 32'h8000_0000 | (16+k).
    - MPIE <= MIE; MIE <= 0.
  - The interrupted instruction is squashed: its CSR write is dropped and minstret is not incremented.
- MRET (instr_valid & is_mret & !take):
  - trap_taken=1, trap_pc=mepc.
  - At the edge: MIE <= MPIE; MPIE <= 1.
- Priority order: interrupt > mret > CSR write. A simultaneous is_mret and csr_op!=0 drops the CSR write.
- Counters:
  - mcycle increments every cycle.
  - minstret increments when retire & instr_valid & !trap_taken.
  - Both are 64-bit and wrap 0xFFFF_FFFF_FFFF_FFFF -> 0.
  - A CSR write to either half replaces that half; the increment for that counter is dropped in that cycle.
- mret with MPIE=1 and pending interrupt: MIE becomes 1 at the edge. The interrupt can be taken on the next valid instruction, not the mret itself.
- rst mid-trap: all state returns to reset values at the edge; no partial update is retained.

Test Plan:
- Reset, then read mstatus, mtvec and mcycle in the 1st cycle -> 0x1800, MTVEC_RESET, 0. trap_taken=0.
- RW mtvec=0x0000_1003, RS mstatus 0x8, RW mie=0x0001_0000. Assert irq_i[0] with pc_i=0x40 -> trap_taken=1 the cycle after the irq (mip latched), trap_pc=0x1000+64=0x1040, mepc=0x40, mcause=0x8000_0010, mstatus reads 0x1880.
- irq_i[0] and irq_i[2] set, both enabled -> mcause=0x8000_0010. Then clear irq 0 and mret -> trap_pc=0x40, MIE=1. Next valid instruction traps with mcause=0x8000_0012.
- RC mstatus 0x8 then assert irq -> no trap. Write mip or 0xC00 -> illegal_csr=1, value unchanged.
- mcycle written 0xFFFF_FFFF, mcycleh written 0xFFFF_FFFF -> after two idle cycles it reads 1/0 (wrap). minstret does not count a squashed instruction.
- Assert rst during a trap cycle -> mepc=0, mcause=0, mstatus=0x1800 on the next cycle.

Source files
------------

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller for the execute stage.
// Handles prioritised interrupts, mret stacking and 64-bit counters.
module csr_trap_unit #(
   parameter int          XLEN        = 32,
   parameter int          NUM_IRQ     = 4,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               instr_valid,
   input  logic [XLEN-1:0]    pc_i,
   input  logic [1:0]         csr_op,
   input  logic [11:0]        csr_addr,
   input  logic [XLEN-1:0]    csr_wdata,
   input  logic               is_mret,
   input  logic               retire,
   input  logic [NUM_IRQ-1:0] irq_i,
   output logic [XLEN-1:0]    csr_rdata,
   output logic               illegal_csr,
   output logic               trap_taken,
   output logic [XLEN-1:0]    trap_pc
);

   localparam logic [11:0] A_MSTATUS   = 12'h300;
   localparam logic [11:0] A_MIE       = 12'h304;
   localparam logic [11:0] A_MTVEC     = 12'h305;
   localparam logic [11:0] A_MSCRATCH  = 12'h340;
   localparam logic [11:0] A_MEPC      = 12'h341;
   localparam logic [11:0] A_MCAUSE    = 12'h342;
   localparam logic [11:0] A_MIP       = 12'h344;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;

   logic               mie_q, mie_d;
   logic               mpie_q, mpie_d;
   logic [NUM_IRQ-1:0] irq_en_q, irq_en_d;
   logic [NUM_IRQ-1:0] mip_q, mip_d;
   logic [XLEN-1:0]    mtvec_q, mtvec_d;
   logic [XLEN-1:0]    mscratch_q, mscratch_d;
   logic [XLEN-1:0]    mepc_q, mepc_d;
   logic [XLEN-1:0]    mcause_q, mcause_d;
   logic [63:0]        mcycle_q, mcycle_d;
   logic [63:0]        minstret_q, minstret_d;

   logic [XLEN-1:0]    csr_val;
   logic [XLEN-1:0]    csr_new;
   logic [XLEN-1:0]    base;
   logic               csr_hit;
   logic               csr_ro;
   logic               access;
   logic               csr_we;
   logic               take;
   logic               mret_go;
   logic               inst_inc;
   logic [NUM_IRQ-1:0] pending;
   logic [4:0]         irq_code;

   always_comb begin
      csr_val = '0;
      csr_hit = 1'b1;
      case (csr_addr)
         A_MSTATUS:   csr_val = XLEN'({mpie_q, 3'b000, mie_q, 3'b000})
                              | XLEN'(32'h1800);
         A_MIE:       csr_val = XLEN'(irq_en_q) << 16;
         A_MTVEC:     csr_val = mtvec_q;
         A_MSCRATCH:  csr_val = mscratch_q;
         A_MEPC:      csr_val = mepc_q;
         A_MCAUSE:    csr_val = mcause_q;
         A_MIP:       csr_val = XLEN'(mip_q) << 16;
         A_MCYCLE:    csr_val = mcycle_q[31:0];
         A_MCYCLEH:   csr_val = mcycle_q[63:32];
         A_MINSTRET:  csr_val = minstret_q[31:0];
         A_MINSTRETH: csr_val = minstret_q[63:32];
         default:     csr_hit = 1'b0;
      endcase
   end

   always_comb begin
      access      = instr_valid && (csr_op != 2'b00);
      csr_ro      = (csr_addr == A_MIP) || (csr_addr[11:10] == 2'b11);
      illegal_csr = access && (!csr_hit || csr_ro);
      csr_rdata   = (access && !illegal_csr) ? csr_val : '0;
      case (csr_op)
         2'b01:   csr_new = csr_wdata;
         2'b10:   csr_new = csr_val | csr_wdata;
         2'b11:   csr_new = csr_val & ~csr_wdata;
         default: csr_new = csr_val;
      endcase
   end

   // Lowest-numbered pending line wins.
   always_comb begin
      pending  = mip_q & irq_en_q;
      irq_code = 5'd16;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (pending[i]) irq_code = 5'(16 + i);
      end
      take       = instr_valid && mie_q && (|pending);
      mret_go    = instr_valid && is_mret && !take;
      csr_we     = access && !illegal_csr && !take && !mret_go;
      trap_taken = take || mret_go;
      inst_inc   = retire && instr_valid && !trap_taken;
      base       = {mtvec_q[XLEN-1:2], 2'b00};
      trap_pc    = '0;
      if (take) begin
         trap_pc = mtvec_q[0] ? base + (XLEN'(irq_code) << 2) : base;
      end else if (mret_go) begin
         trap_pc = mepc_q;
      end
   end

   always_comb begin
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      irq_en_d   = irq_en_q;
      mip_d      = irq_i;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mcycle_d   = mcycle_q + 64'd1;
      minstret_d = minstret_q + {63'd0, inst_inc};
      if (take) begin
         mepc_d   = pc_i & ~XLEN'(3);
         mcause_d = {1'b1, {(XLEN-6){1'b0}}, irq_code};
         mpie_d   = mie_q;
         mie_d    = 1'b0;
      end else if (mret_go) begin
         mie_d  = mpie_q;
         mpie_d = 1'b1;
      end else if (csr_we) begin
         case (csr_addr)
            A_MSTATUS: begin
               mie_d  = csr_new[3];
               mpie_d = csr_new[7];
            end
            A_MIE:       irq_en_d   = csr_new[16 +: NUM_IRQ];
            A_MTVEC:     mtvec_d    = csr_new & ~XLEN'(2);
            A_MSCRATCH:  mscratch_d = csr_new;
            A_MEPC:      mepc_d     = csr_new & ~XLEN'(3);
            A_MCAUSE:    mcause_d   = csr_new;
            A_MCYCLE:    mcycle_d   = {mcycle_q[63:32], csr_new};
            A_MCYCLEH:   mcycle_d   = {csr_new, mcycle_q[31:0]};
            A_MINSTRET:  minstret_d = {minstret_q[63:32], csr_new};
            A_MINSTRETH: minstret_d = {csr_new, minstret_q[31:0]};
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         irq_en_q   <= '0;
         mip_q      <= '0;
         mtvec_q    <= MTVEC_RESET & ~XLEN'(2);
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         irq_en_q   <= irq_en_d;
         mip_q      <= mip_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end

endmodule
